pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Collects stall requests from IF, ID, EX and MEM and branch redirects from ID.
- Drives the per-stage hold vector consumed by the PC register, IF_ID and the downstream stage registers, plus the IF_ID flush and PC redirect.
- Owns the multi-cycle EX occupancy counter (mult/div) and a pending-redirect buffer for branches resolved while fetch is stalled.

Parameters:
- ADDR_W, 32, PC/branch target width (matches INST_ADDR_BUS).
- CNT_W, 6, width of the EX multi-cycle count.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- if_stallreq  in  1  fetch waiting on instruction memory
- id_stallreq  in  1  load-use hazard detected in ID
- ex_multi_start  in  1  EX issues a multi-cycle op this cycle
- ex_multi_cycles  in  CNT_W  total EX occupancy in cycles for that op
- mem_stallreq  in  1  data memory wait
- id_branch_taken  in  1  ID resolved a taken branch/jump
- id_branch_target  in  ADDR_W  redirect target
- stall  out  6  hold bits: [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB, [5] WB
- flush_if_id  out  1  load a bubble (all-zero) into IF_ID
- pc_redirect  out  1  PC loads redirect_pc next edge
- redirect_pc  out  ADDR_W  redirect target
- ex_busy  out  1  multi-cycle op in progress
- ex_multi_done  out  1  one-cycle pulse when the op completes

Behaviour:
- Reset (synchronous, active-high):
  - FSM to IDLE, counter 0, pending_valid 0, pending_pc 0.
  - All outputs 0.
  - Reset mid-operation aborts any EX op or pending redirect without a done pulse.
- Stall vector: combinational, same-cycle. Priority is highest first:
  - mem_stallreq -> 6'b011111
  - ex stall (FSM BUSY, or IDLE with ex_multi_start and ex_multi_cycles>1) -> 6'b001111
  - id_stallreq -> 6'b000111
  - if_stallreq -> 6'b000011
  - otherwise 0
- EX FSM states: IDLE, BUSY, DONE.
  - IDLE, ex_multi_start with N=ex_multi_cycles:
    - N<=1: no stall, go to DONE.
    - N>=2: load cnt=N-1, go to BUSY; the start cycle is stalled.
  - BUSY: stall asserted, ex_busy=1, cnt decrements each cycle. When cnt==1, go to DONE. Total stalled cycles = N-1; the op leaves EX on cycle N.
  - The counter runs regardless of mem_stallreq.
  - DONE: ex_multi_done=1 for one cycle, then IDLE. A new ex_multi_start in DONE is accepted exactly as in IDLE.
  - ex_multi_start is ignored in BUSY.
- Branch handling:
  - id_branch_taken is honoured only when stall[2]==0. If ID is held, the branch is ignored; ID re-presents it next cycle.
  - Honoured and stall[0]==0: pc_redirect=1, redirect_pc=id_branch_target, flush_if_id=1, all in the same cycle.
  - Honoured but stall[0]==1 (fetch stall only): latch pending_pc=target and pending_valid=1; no flush this cycle.
  - While pending_valid and stall[0]==0: pc_redirect=1, redirect_pc=pending_pc, flush_if_id=1, then clear pending_valid.
  - A new honoured branch overwrites pending_pc. It cannot coexist with a pending one in practice; if it does, the newest wins.
- flush_if_id is never asserted while stall[1]==1.
- No output depends combinationally on pc_redirect. stall, flush and redirect are combinational from inputs and registered state; all state is registered on posedge clk.

Decomposition:
- Shared package/defines:
  - stall bit indices (STALL_PC..STALL_WB)
  - STALL_W=6
  - the four stall pattern constants
  - FSM state encodings (2 bits)
- One sub-module: ex_occupancy_fsm. It holds the IDLE/BUSY/DONE FSM and counter, with outputs ex_stall, ex_busy and ex_multi_done.
- Priority encoding and redirect buffer stay in pipe_ctrl.

Test Plan:
- Reset: assert rst 2 cycles with all requests high -> stall=0, flush_if_id=0, pc_redirect=0, ex_busy=0 during and after.
- Priority: mem_stallreq=1, id_stallreq=1, if_stallreq=1 -> stall=6'b011111; drop mem -> 6'b000111; drop id -> 6'b000011.
- Multi-cycle: ex_multi_start with ex_multi_cycles=4 -> stall=6'b001111 for 3 cycles (start + 2 BUSY), ex_multi_done pulses on cycle 4. ex_multi_start during BUSY is ignored. N=1 -> no stall, done next cycle.
- Branch direct: id_branch_taken=1, target 0x0000_0040, no stalls -> same cycle pc_redirect=1, redirect_pc=0x40, flush_if_id=1.
- Branch under fetch stall: if_stallreq=1 for 3 cycles with branch taken in cycle 1 to 0x80 -> no redirect while stalled; redirect to 0x80 with flush in the first cycle if_stallreq=0; pending cleared afterwards.
- Branch under ID stall and reset: branch with id_stallreq=1 -> ignored, no pending latch. Reset during BUSY with cnt=5 -> ex_busy=0 next cycle, no done pulse.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Contents: stall vector width and bit indices, the four priority stall
// patterns, and the EX occupancy FSM state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W  = 6;
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;
    localparam int STALL_EX = 3;
    localparam int STALL_MM = 4;
    localparam int STALL_WB = 5;

    // Each pattern holds its own stage and everything upstream of it.
    localparam logic [STALL_W-1:0] STALL_PAT_MEM = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_PAT_EX  = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_PAT_ID  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_PAT_IF  = 6'b000011;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

endpackage

// File: rtl/pipe_ctrl_ex_occupancy_fsm.sv
// EX multi-cycle occupancy tracker (mult/div).
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   start, cycles       EX issues an op occupying 'cycles' cycles
//   ex_stall            hold EX and upstream this cycle
//   ex_busy             op in progress (BUSY state)
//   ex_multi_done       one-cycle pulse on the cycle the op leaves EX
// An N-cycle op stalls the start cycle plus N-2 BUSY cycles (N-1 total),
// and DONE is cycle N. N==2 therefore skips BUSY entirely.
module ex_occupancy_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    output logic             ex_stall,
    output logic             ex_busy,
    output logic             ex_multi_done
);

    ex_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EX_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ex_stall      = 1'b0;
        ex_busy       = 1'b0;
        ex_multi_done = 1'b0;
        case (state)
            EX_IDLE, EX_DONE: begin
                ex_multi_done = (state == EX_DONE);
                state_nxt     = EX_IDLE;
                if (start) begin
                    if (cycles > CNT_W'(1)) begin
                        ex_stall  = 1'b1;
                        cnt_nxt   = cycles - CNT_W'(1);
                        state_nxt = (cycles == CNT_W'(2)) ? EX_DONE : EX_BUSY;
                    end else begin
                        state_nxt = EX_DONE;
                    end
                end
            end
            EX_BUSY: begin
                ex_stall = 1'b1;
                ex_busy  = 1'b1;
                cnt_nxt  = cnt - CNT_W'(1);
                // Leave BUSY as the count reaches 1; next cycle is DONE.
                if (cnt == CNT_W'(2))
                    state_nxt = EX_DONE;
            end
            default: state_nxt = EX_IDLE;
        endcase
        // Outputs read as zero for the whole reset cycle.
        if (rst) begin
            ex_stall      = 1'b0;
            ex_busy       = 1'b0;
            ex_multi_done = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   if/id/mem_stallreq        per-stage stall requests
//   ex_multi_start/_cycles    multi-cycle EX op issue and its occupancy
//   id_branch_taken/_target   taken branch resolved in ID
//   stall[5:0]                hold bits PC, IF_ID, ID_EX, EX_MEM, MEM_WB, WB
//   flush_if_id               bubble into IF_ID
//   pc_redirect, redirect_pc  PC load of redirect target
//   ex_busy, ex_multi_done    EX occupancy status
// Branches resolved while only fetch is stalled are parked in a one-entry
// buffer and replayed on the first cycle the PC is free.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stallreq,
    input  logic               id_stallreq,
    input  logic               ex_multi_start,
    input  logic [CNT_W-1:0]   ex_multi_cycles,
    input  logic               mem_stallreq,
    input  logic               id_branch_taken,
    input  logic [ADDR_W-1:0]  id_branch_target,
    output logic [STALL_W-1:0] stall,
    output logic               flush_if_id,
    output logic               pc_redirect,
    output logic [ADDR_W-1:0]  redirect_pc,
    output logic               ex_busy,
    output logic               ex_multi_done
);

    logic              ex_stall;
    logic              pending_valid;
    logic [ADDR_W-1:0] pending_pc;
    logic              br_ok;
    logic              go_new, go_pend;

    ex_occupancy_fsm #(.CNT_W(CNT_W)) u_ex_fsm (
        .clk           (clk),
        .rst           (rst),
        .start         (ex_multi_start),
        .cycles        (ex_multi_cycles),
        .ex_stall      (ex_stall),
        .ex_busy       (ex_busy),
        .ex_multi_done (ex_multi_done)
    );

    always_comb begin
        stall = '0;
        if (rst)               stall = '0;
        else if (mem_stallreq) stall = STALL_PAT_MEM;
        else if (ex_stall)     stall = STALL_PAT_EX;
        else if (id_stallreq)  stall = STALL_PAT_ID;
        else if (if_stallreq)  stall = STALL_PAT_IF;
    end

    // A branch held in ID is simply re-presented next cycle.
    assign br_ok   = !rst && id_branch_taken && !stall[STALL_ID];
    // A fresh branch beats a parked one (newest wins).
    assign go_new  = br_ok && !stall[STALL_PC];
    assign go_pend = !rst && !go_new && pending_valid && !stall[STALL_PC];

    always_comb begin
        pc_redirect = go_new || go_pend;
        flush_if_id = (go_new || go_pend) && !stall[STALL_IF];
        redirect_pc = '0;
        if (go_new)       redirect_pc = id_branch_target;
        else if (go_pend) redirect_pc = pending_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_valid <= 1'b0;
            pending_pc    <= '0;
        end else if (br_ok && stall[STALL_PC]) begin
            pending_valid <= 1'b1;
            pending_pc    <= id_branch_target;
        end else if (go_new || go_pend) begin
            pending_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, if_stallreq, id_stallreq, ex_multi_start, mem_stallreq, id_branch_taken;
    logic [5:0]  ex_multi_cycles;
    logic [31:0] id_branch_target;
    logic [5:0]  stall;
    logic        flush_if_id, pc_redirect, ex_busy, ex_multi_done;
    logic [31:0] redirect_pc;

    pipe_ctrl #(.ADDR_W(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .if_stallreq(if_stallreq), .id_stallreq(id_stallreq),
        .ex_multi_start(ex_multi_start), .ex_multi_cycles(ex_multi_cycles),
        .mem_stallreq(mem_stallreq), .id_branch_taken(id_branch_taken),
        .id_branch_target(id_branch_target), .stall(stall), .flush_if_id(flush_if_id),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .ex_busy(ex_busy),
        .ex_multi_done(ex_multi_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, mem, id, ifs, st, br;
        logic [5:0]  n;
        logic [31:0] tg;
    } in_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush, redir;
        logic [31:0] rpc;
        logic        busy, done;
    } exp_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  e;
    } vec_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    failures = 0;

    function automatic in_t mk_in(logic r, logic m, logic i, logic f, logic s,
                                  logic [5:0] n, logic b, logic [31:0] t);
        in_t x;
        x.rst = r; x.mem = m; x.id = i; x.ifs = f; x.st = s; x.n = n; x.br = b; x.tg = t;
        return x;
    endfunction

    function automatic exp_t mk_exp(logic [5:0] s, logic fl, logic rd, logic [31:0] pc,
                                    logic bz, logic dn);
        exp_t x;
        x.stall = s; x.flush = fl; x.redir = rd; x.rpc = pc; x.busy = bz; x.done = dn;
        return x;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare at negedge.
    task automatic cyc(input in_t in, input exp_t e, input string nm);
        exp_t  x;
        string n;
        rst = in.rst; mem_stallreq = in.mem; id_stallreq = in.id; if_stallreq = in.ifs;
        ex_multi_start = in.st; ex_multi_cycles = in.n;
        id_branch_taken = in.br; id_branch_target = in.tg;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        x = sb_q.pop_front();
        n = nm_q.pop_front();
        checks++;
        if (stall !== x.stall || flush_if_id !== x.flush || pc_redirect !== x.redir ||
            redirect_pc !== x.rpc || ex_busy !== x.busy || ex_multi_done !== x.done) begin
            failures++;
            $display("FAIL %s: got stall=%b flush=%b redir=%b pc=%h busy=%b done=%b, want stall=%b flush=%b redir=%b pc=%h busy=%b done=%b",
                     n, stall, flush_if_id, pc_redirect, redirect_pc, ex_busy, ex_multi_done,
                     x.stall, x.flush, x.redir, x.rpc, x.busy, x.done);
        end
        @(posedge clk);
        #1;
    endtask

    in_t  z;
    exp_t e0;
    vec_t tbl[9];

    initial begin
        z  = mk_in(0, 0, 0, 0, 0, 6'd0, 0, 32'h0);
        e0 = mk_exp(6'b0, 0, 0, 32'h0, 0, 0);

        tbl[0] = '{"idle",        z,                                          e0};
        tbl[1] = '{"prio_all",    mk_in(0, 1, 1, 1, 0, 6'd0, 0, 32'h0),       mk_exp(6'b011111, 0, 0, 32'h0, 0, 0)};
        tbl[2] = '{"prio_id_if",  mk_in(0, 0, 1, 1, 0, 6'd0, 0, 32'h0),       mk_exp(6'b000111, 0, 0, 32'h0, 0, 0)};
        tbl[3] = '{"prio_if",     mk_in(0, 0, 0, 1, 0, 6'd0, 0, 32'h0),       mk_exp(6'b000011, 0, 0, 32'h0, 0, 0)};
        tbl[4] = '{"prio_mem",    mk_in(0, 1, 0, 0, 0, 6'd0, 0, 32'h0),       mk_exp(6'b011111, 0, 0, 32'h0, 0, 0)};
        tbl[5] = '{"br_direct",   mk_in(0, 0, 0, 0, 0, 6'd0, 1, 32'h40),      mk_exp(6'b0, 1, 1, 32'h40, 0, 0)};
        tbl[6] = '{"br_id_stall", mk_in(0, 0, 1, 0, 0, 6'd0, 1, 32'h44),      mk_exp(6'b000111, 0, 0, 32'h0, 0, 0)};
        tbl[7] = '{"no_pend_id",  z,                                          e0};
        tbl[8] = '{"br_mem_stall",mk_in(0, 1, 0, 1, 0, 6'd0, 1, 32'h48),      mk_exp(6'b011111, 0, 0, 32'h0, 0, 0)};

        // Reset with every request high: outputs stay quiet throughout.
        @(posedge clk); #1;
        cyc(mk_in(1, 1, 1, 1, 1, 6'd4, 1, 32'h40), e0, "rst_c1");
        cyc(mk_in(1, 1, 1, 1, 1, 6'd4, 1, 32'h40), e0, "rst_c2");
        cyc(z, e0, "post_rst");

        for (int i = 0; i < 9; i++) cyc(tbl[i].in, tbl[i].e, tbl[i].name);
        cyc(z, e0, "no_pend_mem");

        // N=4: three stalled cycles, start during BUSY ignored, done on cycle 4.
        cyc(mk_in(0, 0, 0, 0, 1, 6'd4, 0, 32'h0), mk_exp(6'b001111, 0, 0, 32'h0, 0, 0), "n4_start");
        cyc(mk_in(0, 0, 0, 0, 1, 6'd4, 0, 32'h0), mk_exp(6'b001111, 0, 0, 32'h0, 1, 0), "n4_busy1");
        cyc(z, mk_exp(6'b001111, 0, 0, 32'h0, 1, 0), "n4_busy2");
        cyc(z, mk_exp(6'b0, 0, 0, 32'h0, 0, 1), "n4_done");
        cyc(z, e0, "n4_after");

        // N=1: no stall, done next cycle.
        cyc(mk_in(0, 0, 0, 0, 1, 6'd1, 0, 32'h0), e0, "n1_start");
        cyc(z, mk_exp(6'b0, 0, 0, 32'h0, 0, 1), "n1_done");
        cyc(z, e0, "n1_after");

        // Branch under fetch stall is parked and replayed when fetch frees.
        cyc(mk_in(0, 0, 0, 1, 0, 6'd0, 1, 32'h80), mk_exp(6'b000011, 0, 0, 32'h0, 0, 0), "pend_c1");
        cyc(mk_in(0, 0, 0, 1, 0, 6'd0, 0, 32'h0),  mk_exp(6'b000011, 0, 0, 32'h0, 0, 0), "pend_c2");
        cyc(mk_in(0, 0, 0, 1, 0, 6'd0, 0, 32'h0),  mk_exp(6'b000011, 0, 0, 32'h0, 0, 0), "pend_c3");
        cyc(z, mk_exp(6'b0, 1, 1, 32'h80, 0, 0), "pend_replay");
        cyc(z, e0, "pend_cleared");

        // Reset during BUSY at cnt=5 (N=8): aborts without a done pulse.
        cyc(mk_in(0, 0, 0, 0, 1, 6'd8, 0, 32'h0), mk_exp(6'b001111, 0, 0, 32'h0, 0, 0), "abort_start");
        cyc(z, mk_exp(6'b001111, 0, 0, 32'h0, 1, 0), "abort_b7");
        cyc(z, mk_exp(6'b001111, 0, 0, 32'h0, 1, 0), "abort_b6");
        cyc(mk_in(1, 0, 0, 0, 0, 6'd0, 0, 32'h0), e0, "abort_rst");
        cyc(z, e0, "abort_after1");
        cyc(z, e0, "abort_after2");
        cyc(z, e0, "abort_after3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
